// File: rtl/iob_uart_console_master_pkg.sv
// Shared definitions for the UART console master.
//   - Default iob_uart register map (address width and register addresses).
//   - Byte-strobe constants for 8-bit and 16-bit register writes.
//   - FSM state encoding, exported on the top-level debug_state port.
package iob_uart_console_master_pkg;

    localparam int UART_ADDR_W          = 4;
    localparam int UART_SOFTRESET_ADDR  = 0;
    localparam int UART_DIV_ADDR        = 2;
    localparam int UART_TXDATA_ADDR     = 4;
    localparam int UART_TXEN_ADDR       = 5;
    localparam int UART_RXEN_ADDR       = 6;
    localparam int UART_TXREADY_ADDR    = 8;
    localparam int UART_RXREADY_ADDR    = 9;
    localparam int UART_RXDATA_ADDR     = 10;

    localparam int WSTRB_BYTE = 1;
    localparam int WSTRB_HALF = 3;

    typedef enum logic [3:0] {
        RST_ON   = 4'd0,
        RST_OFF  = 4'd1,
        WR_DIV   = 4'd2,
        WR_TXEN  = 4'd3,
        WR_RXEN  = 4'd4,
        POLL_RX  = 4'd5,
        POLL_TX  = 4'd6,
        READ_RX  = 4'd7,
        WRITE_TX = 4'd8
    } state_t;

endpackage

// File: rtl/iob_uart_cm_fifo.sv
// Small synchronous FIFO holding received UART bytes.
// Ports:
//   clk, reset (async, active-low)
//   push, push_data : write one entry (ignored when full)
//   pop             : drop the head entry (ignored when empty)
//   pop_data        : head entry, valid while empty = 0
//   full, empty     : occupancy flags
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module iob_uart_cm_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] pop_data,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         do_push;
    logic         do_pop;

    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr[AW-1:0]] <= push_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: rtl/iob_uart_console_master.sv
// Hardware console loop in front of the iob_uart native slave port.
// Configures the UART (soft reset, divisor, TX/RX enable), then alternates
// between polling RX readiness and TX readiness forever.
// Ports:
//   clk, reset          : clock, async active-low reset
//   uart_valid/addr/wdata/wstrb : registered bus request (wstrb = 0 is a read)
//   uart_rdata, uart_ready      : slave response, sampled only with ready
//   tx_valid/tx_data/tx_ready   : byte stream to transmit
//   rx_valid/rx_data/rx_ready   : received byte stream (FIFO output)
//   init_done           : UART configured and polling active
//   debug_state         : current FSM state
// Stream handshake: a byte moves when valid and ready are both high in the
// same cycle; the producer holds valid and data stable until that cycle.
// Bus handshake: request fields stay stable while uart_valid is high and
// uart_ready is low; uart_valid drops the cycle after uart_ready.
module iob_uart_console_master
    import iob_uart_console_master_pkg::*;
#(
    parameter int          DATA_W         = 32,
    parameter int          ADDR_W         = UART_ADDR_W,
    parameter logic [15:0] UART_DIV       = 16'd100,
    parameter int          RX_FIFO_DEPTH  = 4,
    parameter int          SOFTRESET_ADDR = UART_SOFTRESET_ADDR,
    parameter int          DIV_ADDR       = UART_DIV_ADDR,
    parameter int          TXEN_ADDR      = UART_TXEN_ADDR,
    parameter int          RXEN_ADDR      = UART_RXEN_ADDR,
    parameter int          TXREADY_ADDR   = UART_TXREADY_ADDR,
    parameter int          RXREADY_ADDR   = UART_RXREADY_ADDR,
    parameter int          TXDATA_ADDR    = UART_TXDATA_ADDR,
    parameter int          RXDATA_ADDR    = UART_RXDATA_ADDR
) (
    input  logic                clk,
    input  logic                reset,
    output logic                uart_valid,
    output logic [ADDR_W-1:0]   uart_addr,
    output logic [DATA_W-1:0]   uart_wdata,
    output logic [DATA_W/8-1:0] uart_wstrb,
    input  logic [DATA_W-1:0]   uart_rdata,
    input  logic                uart_ready,
    input  logic                tx_valid,
    input  logic [7:0]          tx_data,
    output logic                tx_ready,
    output logic                rx_valid,
    output logic [7:0]          rx_data,
    input  logic                rx_ready,
    output logic                init_done,
    output logic [3:0]          debug_state
);

    localparam int STRB_W = DATA_W / 8;

    localparam logic [ADDR_W-1:0] A_SOFTRESET = ADDR_W'(SOFTRESET_ADDR);
    localparam logic [ADDR_W-1:0] A_DIV       = ADDR_W'(DIV_ADDR);
    localparam logic [ADDR_W-1:0] A_TXEN      = ADDR_W'(TXEN_ADDR);
    localparam logic [ADDR_W-1:0] A_RXEN      = ADDR_W'(RXEN_ADDR);
    localparam logic [ADDR_W-1:0] A_TXREADY   = ADDR_W'(TXREADY_ADDR);
    localparam logic [ADDR_W-1:0] A_RXREADY   = ADDR_W'(RXREADY_ADDR);
    localparam logic [ADDR_W-1:0] A_TXDATA    = ADDR_W'(TXDATA_ADDR);
    localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(RXDATA_ADDR);

    localparam logic [STRB_W-1:0] S_BYTE = STRB_W'(WSTRB_BYTE);
    localparam logic [STRB_W-1:0] S_HALF = STRB_W'(WSTRB_HALF);

    state_t              state;
    state_t              state_next;
    logic                done;
    logic                skip;
    logic                issue;
    logic [ADDR_W-1:0]   req_addr;
    logic [DATA_W-1:0]   req_wdata;
    logic [STRB_W-1:0]   req_wstrb;
    logic                set_init_done;
    logic                fifo_push;
    logic                fifo_full;
    logic                fifo_empty;
    logic                unused_rdata;

    assign done         = uart_valid && uart_ready;
    // Every state issues its request in the first cycle it sees the bus idle,
    // unless it is a poll state that decides to skip its read.
    assign issue        = !uart_valid && !skip;
    assign tx_ready     = (state == WRITE_TX) && done;
    assign rx_valid     = !fifo_empty;
    assign debug_state  = state;
    assign unused_rdata = ^uart_rdata[DATA_W-1:8];

    always_comb begin
        state_next    = state;
        skip          = 1'b0;
        req_addr      = '0;
        req_wdata     = '0;
        req_wstrb     = '0;
        set_init_done = 1'b0;
        fifo_push     = 1'b0;
        case (state)
            RST_ON: begin
                req_addr  = A_SOFTRESET;
                req_wdata = DATA_W'(1);
                req_wstrb = S_BYTE;
                if (done) state_next = RST_OFF;
            end
            RST_OFF: begin
                req_addr  = A_SOFTRESET;
                req_wstrb = S_BYTE;
                if (done) state_next = WR_DIV;
            end
            WR_DIV: begin
                req_addr  = A_DIV;
                req_wdata = DATA_W'(UART_DIV);
                req_wstrb = S_HALF;
                if (done) state_next = WR_TXEN;
            end
            WR_TXEN: begin
                req_addr  = A_TXEN;
                req_wdata = DATA_W'(1);
                req_wstrb = S_BYTE;
                if (done) state_next = WR_RXEN;
            end
            WR_RXEN: begin
                req_addr  = A_RXEN;
                req_wdata = DATA_W'(1);
                req_wstrb = S_BYTE;
                if (done) begin
                    state_next    = POLL_RX;
                    set_init_done = 1'b1;
                end
            end
            POLL_RX: begin
                req_addr = A_RXREADY;
                // Only READ_RX pushes, so fullness cannot change while a
                // RXREADY read is outstanding.
                if (!uart_valid && fifo_full) begin
                    skip       = 1'b1;
                    state_next = POLL_TX;
                end else if (done) begin
                    state_next = uart_rdata[0] ? READ_RX : POLL_TX;
                end
            end
            POLL_TX: begin
                req_addr = A_TXREADY;
                if (!uart_valid && !tx_valid) begin
                    skip       = 1'b1;
                    state_next = POLL_RX;
                end else if (done) begin
                    state_next = uart_rdata[0] ? WRITE_TX : POLL_RX;
                end
            end
            READ_RX: begin
                req_addr = A_RXDATA;
                if (done) begin
                    fifo_push  = 1'b1;
                    state_next = POLL_TX;
                end
            end
            WRITE_TX: begin
                req_addr  = A_TXDATA;
                req_wdata = DATA_W'(tx_data);
                req_wstrb = S_BYTE;
                if (done) state_next = POLL_RX;
            end
            default: begin
                state_next = RST_ON;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= RST_ON;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            uart_valid <= 1'b0;
            uart_addr  <= '0;
            uart_wdata <= '0;
            uart_wstrb <= '0;
            init_done  <= 1'b0;
        end else begin
            if (done) begin
                uart_valid <= 1'b0;
            end else if (issue) begin
                uart_valid <= 1'b1;
                uart_addr  <= req_addr;
                uart_wdata <= req_wdata;
                uart_wstrb <= req_wstrb;
            end
            if (set_init_done) begin
                init_done <= 1'b1;
            end
        end
    end

    iob_uart_cm_fifo #(
        .DEPTH (RX_FIFO_DEPTH),
        .W     (8)
    ) u_rx_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (fifo_push),
        .push_data (uart_rdata[7:0]),
        .pop       (rx_valid && rx_ready),
        .pop_data  (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

endmodule

// File: tb/tb_iob_uart_console_master.sv
// Self-checking bench for iob_uart_console_master: a behavioural UART slave
// with random wait states, a transaction log, and an RX byte scoreboard.
module tb_iob_uart_console_master;
    import iob_uart_console_master_pkg::*;

    localparam int DW = 32;
    localparam int AW = UART_ADDR_W;
    localparam int SW = DW / 8;

    localparam logic [AW-1:0] A_SR   = AW'(UART_SOFTRESET_ADDR);
    localparam logic [AW-1:0] A_DIV  = AW'(UART_DIV_ADDR);
    localparam logic [AW-1:0] A_TXEN = AW'(UART_TXEN_ADDR);
    localparam logic [AW-1:0] A_RXEN = AW'(UART_RXEN_ADDR);
    localparam logic [AW-1:0] A_TXR  = AW'(UART_TXREADY_ADDR);
    localparam logic [AW-1:0] A_RXR  = AW'(UART_RXREADY_ADDR);
    localparam logic [AW-1:0] A_TXD  = AW'(UART_TXDATA_ADDR);
    localparam logic [AW-1:0] A_RXD  = AW'(UART_RXDATA_ADDR);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    logic          uart_valid;
    logic [AW-1:0] uart_addr;
    logic [DW-1:0] uart_wdata;
    logic [SW-1:0] uart_wstrb;
    logic [DW-1:0] uart_rdata = '0;
    logic          uart_ready = 1'b0;
    logic          tx_valid = 1'b0;
    logic [7:0]    tx_data = '0;
    logic          tx_ready;
    logic          rx_valid;
    logic [7:0]    rx_data;
    logic          rx_ready = 1'b0;
    logic          init_done;
    logic [3:0]    debug_state;

    iob_uart_console_master #(
        .DATA_W        (DW),
        .ADDR_W        (AW),
        .UART_DIV      (16'd100),
        .RX_FIFO_DEPTH (4)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .uart_valid  (uart_valid),
        .uart_addr   (uart_addr),
        .uart_wdata  (uart_wdata),
        .uart_wstrb  (uart_wstrb),
        .uart_rdata  (uart_rdata),
        .uart_ready  (uart_ready),
        .tx_valid    (tx_valid),
        .tx_data     (tx_data),
        .tx_ready    (tx_ready),
        .rx_valid    (rx_valid),
        .rx_data     (rx_data),
        .rx_ready    (rx_ready),
        .init_done   (init_done),
        .debug_state (debug_state)
    );

    // ---------------- check bookkeeping ----------------
    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    // ---------------- UART slave model ----------------
    logic [7:0] rx_src_q[$];     // bytes the UART has received, oldest first
    int  tx_busy_cnt = 0;        // number of TXREADY reads that answer 0
    int  n_txrdy0    = 0;
    int  max_wait    = 0;
    bit  hold_div    = 1'b0;     // never complete a DIV write while set
    int  rxrdy1_cyc  = -1;       // cycle of the latest RXREADY read answering 1

    bit            active = 1'b0;
    int            wait_left = 0;
    logic [AW-1:0] cap_addr;
    logic [DW-1:0] cap_wdata;
    logic [SW-1:0] cap_wstrb;

    function automatic logic [DW-1:0] respond(input logic [AW-1:0] a);
        logic [DW-1:0] r;
        r = $urandom();
        if (a == A_RXR) begin
            r[0] = (rx_src_q.size() != 0);
            if (r[0]) rxrdy1_cyc = cyc;
        end else if (a == A_TXR) begin
            r[0] = (tx_busy_cnt == 0);
            if (tx_busy_cnt > 0) begin
                tx_busy_cnt--;
                n_txrdy0++;
            end
        end else if (a == A_RXD) begin
            r[7:0] = (rx_src_q.size() != 0) ? rx_src_q.pop_front() : 8'h00;
        end
        return r;
    endfunction

    always @(posedge clk) begin
        #1;
        uart_ready = 1'b0;
        uart_rdata = $urandom();
        if (!uart_valid) begin
            active = 1'b0;
        end else begin
            if (!active) begin
                active    = 1'b1;
                wait_left = $urandom_range(0, max_wait);
                cap_addr  = uart_addr;
                cap_wdata = uart_wdata;
                cap_wstrb = uart_wstrb;
            end else begin
                chk("stable_addr", 32'(uart_addr), 32'(cap_addr));
                chk("stable_wdata", uart_wdata, cap_wdata);
                chk("stable_wstrb", 32'(uart_wstrb), 32'(cap_wstrb));
            end
            if (!(hold_div && uart_addr == A_DIV)) begin
                if (wait_left == 0) begin
                    uart_ready = 1'b1;
                    uart_rdata = respond(uart_addr);
                end else begin
                    wait_left--;
                end
            end
        end
    end

    // ---------------- monitors / scoreboard ----------------
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [SW-1:0] wstrb;
        int            cyc;
    } txn_t;

    txn_t       log_q[$];
    logic [7:0] exp_q[$];        // expected RX bytes in delivery order
    int         n_tx_pulse = 0;

    always @(negedge clk) begin
        if (reset && uart_valid && uart_ready)
            log_q.push_back('{addr: uart_addr, wdata: uart_wdata, wstrb: uart_wstrb, cyc: cyc});
        if (tx_ready) begin
            n_tx_pulse++;
            chk("tx_ready_needs_init", 32'(init_done), 32'd1);
        end
        if (rx_valid && rx_ready) begin
            if (exp_q.size() == 0) chk("rx_unexpected", 32'(rx_data), 32'hFFFF_FFFF);
            else chk("rx_byte", 32'(rx_data), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    function automatic int count_log(input int from, input logic [AW-1:0] a);
        int n = 0;
        for (int i = from; i < log_q.size(); i++)
            if (log_q[i].addr == a) n++;
        return n;
    endfunction

    function automatic int find_nth(input int from, input logic [AW-1:0] a, input int nth);
        int n = 0;
        for (int i = from; i < log_q.size(); i++) begin
            if (log_q[i].addr == a) begin
                n++;
                if (n == nth) return i;
            end
        end
        return -1;
    endfunction

    task automatic check_init(input int from);
        logic [AW-1:0] e_addr[5]  = '{A_SR, A_SR, A_DIV, A_TXEN, A_RXEN};
        logic [DW-1:0] e_wdata[5] = '{32'd1, 32'd0, 32'd100, 32'd1, 32'd1};
        logic [SW-1:0] e_wstrb[5] = '{4'd1, 4'd1, 4'd3, 4'd1, 4'd1};
        int n = 0;
        while (!init_done && n < 200) begin
            tick();
            n++;
        end
        chk("init_done_rise", 32'(init_done), 32'd1);
        chk("init_log_len", 32'(log_q.size() >= from + 5), 32'd1);
        if (log_q.size() >= from + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("init%0d_addr", i), 32'(log_q[from+i].addr), 32'(e_addr[i]));
                chk($sformatf("init%0d_wdata", i), log_q[from+i].wdata, e_wdata[i]);
                chk($sformatf("init%0d_wstrb", i), 32'(log_q[from+i].wstrb), 32'(e_wstrb[i]));
            end
            chk("init_done_cycle", 32'(cyc), 32'(log_q[from+4].cyc + 1));
        end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int mark;
        int mark2;
        int n;
        int ri;
        int ti;
        bit found;
        logic [7:0] b;
        logic [7:0] t;

        // Reset state
        repeat (3) tick();
        chk("rst_uart_valid", 32'(uart_valid), 32'd0);
        chk("rst_uart_addr", 32'(uart_addr), 32'd0);
        chk("rst_uart_wdata", uart_wdata, 32'd0);
        chk("rst_uart_wstrb", 32'(uart_wstrb), 32'd0);
        chk("rst_tx_ready", 32'(tx_ready), 32'd0);
        chk("rst_rx_valid", 32'(rx_valid), 32'd0);
        chk("rst_rx_data", 32'(rx_data), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);

        // Init sequence with a zero-wait slave
        reset = 1'b1;
        tick();
        chk("first_valid", 32'(uart_valid), 32'd1);
        chk("first_addr", 32'(uart_addr), 32'(A_SR));
        check_init(0);

        // Reset while the DIV write is stalled restarts the whole init
        reset = 1'b0;
        tick();
        hold_div = 1'b1;
        reset = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            tick();
            found = uart_valid && (uart_addr == A_DIV);
        end
        chk("div_pending", 32'(found), 32'd1);
        tick();
        reset = 1'b0;
        #1;
        chk("async_valid_drop", 32'(uart_valid), 32'd0);
        chk("async_init_drop", 32'(init_done), 32'd0);
        tick();
        tick();
        mark = log_q.size();
        hold_div = 1'b0;
        reset = 1'b1;
        check_init(mark);

        // Single RX byte: latency and pop
        exp_q.push_back(8'h41);
        rx_src_q.push_back(8'h41);
        n = 0;
        while (!rx_valid && n < 100) begin
            tick();
            n++;
        end
        chk("rx_valid_set", 32'(rx_valid), 32'd1);
        // The RXREADY request goes out one cycle after POLL_RX is entered.
        chk("rx_latency", 32'(cyc - rxrdy1_cyc), 32'd3);
        chk("rx_data_41", 32'(rx_data), 32'h41);
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        chk("rx_valid_fall", 32'(rx_valid), 32'd0);

        // TX byte with TXREADY busy twice
        mark = log_q.size();
        n_txrdy0 = 0;
        tx_busy_cnt = 2;
        n = n_tx_pulse;
        tx_data = 8'h5A;
        tx_valid = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            found = tx_ready;
        end
        chk("tx_handoff_seen", 32'(found), 32'd1);
        chk("tx_handoff_addr", 32'(uart_addr), 32'(A_TXD));
        chk("tx_handoff_wdata", uart_wdata, 32'h5A);
        chk("tx_handoff_wstrb", 32'(uart_wstrb), 32'd1);
        tick();
        tx_valid = 1'b0;
        repeat (30) tick();
        chk("tx_write_count", 32'(count_log(mark, A_TXD)), 32'd1);
        chk("tx_busy_reads", 32'(n_txrdy0), 32'd2);
        chk("tx_pulse_count", 32'(n_tx_pulse - n), 32'd1);

        // FIFO fill with a stalled consumer
        mark = log_q.size();
        for (int i = 0; i < 10; i++) begin
            b = 8'($urandom_range(0, 255));
            rx_src_q.push_back(b);
            exp_q.push_back(b);
        end
        repeat (80) tick();
        chk("full_rxdata_reads", 32'(count_log(mark, A_RXD)), 32'd4);
        ri = find_nth(mark, A_RXD, 4);
        chk("full_no_polls", 32'((ri < 0) ? -1 : count_log(ri + 1, A_RXR)), 32'd0);
        chk("full_rx_valid", 32'(rx_valid), 32'd1);
        chk("full_head", 32'(rx_data), 32'(exp_q[0]));
        mark2 = log_q.size();
        rx_ready = 1'b1;
        tick();
        rx_ready = 1'b0;
        repeat (40) tick();
        chk("one_pop_one_read", 32'(count_log(mark2, A_RXD)), 32'd1);
        chk("one_pop_one_poll", 32'(count_log(mark2, A_RXR)), 32'd1);
        rx_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 400) begin
            tick();
            n++;
        end
        chk("rx_drained", 32'(exp_q.size()), 32'd0);
        chk("rx_src_empty", 32'(rx_src_q.size()), 32'd0);

        // RX and TX ready together under random wait states
        max_wait = 3;
        for (int r = 0; r < 4; r++) begin
            mark = log_q.size();
            found = 1'b0;
            for (int i = 0; i < 100 && !found; i++) begin
                tick();
                found = uart_valid && (uart_addr == A_RXR) && !uart_ready;
            end
            chk("prio_sync", 32'(found), 32'd1);
            b = 8'($urandom_range(0, 255));
            t = 8'($urandom_range(0, 255));
            rx_src_q.push_back(b);
            exp_q.push_back(b);
            tx_data = t;
            tx_valid = 1'b1;
            found = 1'b0;
            for (int i = 0; i < 200 && !found; i++) begin
                tick();
                found = tx_ready;
            end
            chk("prio_tx_seen", 32'(found), 32'd1);
            chk("prio_tx_wdata", uart_wdata, 32'(t));
            tick();
            tx_valid = 1'b0;
            n = 0;
            while (exp_q.size() != 0 && n < 100) begin
                tick();
                n++;
            end
            chk("prio_rx_drained", 32'(exp_q.size()), 32'd0);
            ri = find_nth(mark, A_RXD, 1);
            ti = find_nth(mark, A_TXD, 1);
            chk("prio_order", 32'((ri >= 0) && (ri < ti)), 32'd1);
        end
        rx_ready = 1'b0;
        max_wait = 0;
        repeat (5) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iob_uart_console_master.md
# iob_uart_console_master

Synthesizable bus master that sits directly upstream of the `iob_uart` core's native slave port. It performs the console polling loop in hardware, so a host-side byte source and sink can reach the UART without a CPU. It initialises the UART, then alternately polls RX and TX readiness. Received bytes go into a small RX FIFO exposed as a byte stream; bytes from an input byte stream are written to TXDATA.

## Interface
Parameters:
- `DATA_W`, 32, native bus data width.
- `ADDR_W`, `` `iob_uart_swreg_ADDR_W ``, UART register address width.
- `UART_DIV`, 16'd100, baud divisor written during init (`FREQ`/`BAUD`).
- `RX_FIFO_DEPTH`, 4, RX FIFO entries; power of 2, ≥2.
- `SOFTRESET_ADDR`, `DIV_ADDR`, `TXEN_ADDR`, `RXEN_ADDR`, `TXREADY_ADDR`, `RXREADY_ADDR`, `TXDATA_ADDR`, `RXDATA_ADDR`: UART register addresses; each defaults to the matching `` `UART_*_ADDR `` macro.

Ports:
- `clk`, in, 1: single clock; all state is on its rising edge.
- `reset`, in, 1: asynchronous, active-low reset.
- `uart_valid`, out, 1: bus request.
- `uart_addr`, out, `ADDR_W`: register address.
- `uart_wdata`, out, `DATA_W`: write data.
- `uart_wstrb`, out, `DATA_W/8`: byte strobes; 0 means a read.
- `uart_rdata`, in, `DATA_W`: read data, valid when `uart_ready`=1.
- `uart_ready`, in, 1: transaction complete.
- `tx_valid`, in, 1 / `tx_data`, in, 8 / `tx_ready`, out, 1: byte stream to be transmitted.
- `rx_valid`, out, 1 / `rx_data`, out, 8 / `rx_ready`, in, 1: received byte stream.
- `init_done`, out, 1: UART configured, polling active.

## Operation
- FSM states: `RST_ON` → `RST_OFF` → `WR_DIV` → `WR_TXEN` → `WR_RXEN` → `POLL_RX` ⇄ `POLL_TX`, plus `READ_RX` and `WRITE_TX`.
- Init writes, in the order above:
  - SOFTRESET: wdata 1, then 0, wstrb 4'b0001.
  - DIV: wdata `UART_DIV`, wstrb 4'b0011.
  - TXEN: wdata 1, wstrb 4'b0001.
  - RXEN: wdata 1, wstrb 4'b0001.
- `init_done` rises in the cycle after the RXEN write completes and stays high until reset.
- `POLL_RX`:
  - Skipped (goes straight to `POLL_TX`) when the FIFO is full.
  - Otherwise reads RXREADY. If `rdata[0]`=1, go to `READ_RX`; else go to `POLL_TX`.
- `READ_RX`: reads RXDATA, pushes `rdata[7:0]` into the FIFO, then goes to `POLL_TX`.
- `POLL_TX`:
  - Skipped (goes to `POLL_RX`) when `tx_valid`=0.
  - Otherwise reads TXREADY. If `rdata[0]`=1, go to `WRITE_TX`; else go to `POLL_RX`.
- `WRITE_TX`: writes `tx_data` to TXDATA with wstrb 4'b0001 and wdata[31:8]=0. `tx_ready` is high for exactly the cycle in which this write completes; that is the byte handoff.
- Priority: when RX and TX are both ready, the RX byte is serviced first, then TX on the next poll. Strict alternation guarantees neither direction starves.
- `rx_valid` = FIFO not empty. A pop happens when `rx_valid & rx_ready`.
- FIFO push and pop in the same cycle are both allowed. Push when full cannot occur, because the RX poll is skipped.
- Pointers are `$clog2(RX_FIFO_DEPTH)+1` bits wide and wrap modulo 2·depth.

## Timing
- Reset values: `uart_valid`=0, `uart_addr`=0, `uart_wdata`=0, `uart_wstrb`=0, `tx_ready`=0, `rx_valid`=0, `rx_data`=0, `init_done`=0, FIFO empty, state `RST_ON`.
- First `uart_valid` is asserted in the first cycle after reset deasserts.
- Bus rules:
  - `uart_valid`, `addr`, `wdata` and `wstrb` are registered and held stable until a cycle with `uart_ready`=1.
  - `uart_valid` drops in the cycle after `ready`, so there is at least one idle cycle between transactions.
  - `uart_rdata` is sampled only when `uart_ready`=1.
- Latency with a zero-wait slave (`ready` in the first valid cycle):
  - Each transaction takes 2 cycles.
  - RX byte: RXREADY poll to `rx_valid` = 4 cycles.
- Reset asserted mid-transaction drops `uart_valid` immediately (asynchronously). Init is re-run from `RST_ON`.
- `tx_ready` is never asserted before `init_done`=1.

## Structure
- Header `iob_uart_console_master.vh` holds the FSM state encodings and the `WSTRB_BYTE`/`WSTRB_HALF` constants.
- Sub-module `iob_uart_cm_fifo`: synchronous FIFO, parameters `DEPTH` and `W=8`, with push/pop/full/empty and the same async active-low reset.

## Test plan
- Reset, then a zero-wait UART model → bus writes in order: SOFTRESET=1, SOFTRESET=0, DIV=100 (wstrb 3), TXEN=1, RXEN=1. `init_done`=1 one cycle after the RXEN write.
- RXREADY returns 1 and RXDATA returns 0x41 → `rx_valid`=1 with `rx_data`=0x41 four cycles after the poll starts. `rx_ready`=1 pops it, and `rx_valid` falls.
- `tx_valid`=1, `tx_data`=0x5A, TXREADY returns 0 twice then 1 → exactly one write of wdata 0x5A to TXDATA with wstrb 1. `tx_ready` pulses one cycle at write completion.
- `RX_FIFO_DEPTH`=4, `rx_ready`=0, RX always ready → exactly 4 RXDATA reads, then no RXREADY polls. One pop → exactly one more RXDATA read.
- RX and TX both ready with a random 0–3 cycle `ready` delay → RXDATA read precedes the TXDATA write. Bus signals stay stable while `ready`=0.
- Reset pulled low during the `WR_DIV` wait → `uart_valid`=0 immediately. After release, the init sequence restarts at SOFTRESET=1.
